// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_if
// Purpose  : CSR access bus and interrupt request/acknowledge handshake
//            between the core controller and irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if;
  // CSR access port (driven by the core, answered by irq_ctrl)
  logic        csr_access_i;
  logic [11:0] csr_addr_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;

  // Interrupt request towards the core controller
  logic        irq_req_o;
  logic [5:0]  irq_cause_o;
  logic        irq_ack_i;

  // Core / controller side
  modport master (
    output csr_access_i, csr_addr_i, csr_op_i, csr_wdata_i, irq_ack_i,
    input  csr_rdata_o, csr_hit_o, irq_req_o, irq_cause_o
  );

  // Interrupt controller side
  modport slave (
    input  csr_access_i, csr_addr_i, csr_op_i, csr_wdata_i, irq_ack_i,
    output csr_rdata_o, csr_hit_o, irq_req_o, irq_cause_o
  );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Machine-mode interrupt controller. Synchronises interrupt lines,
//            owns mie (0x304) and read-only mip (0x344), arbitrates enabled
//            pending sources by fixed priority and issues one request with
//            an exc_cause_e cause over a req/ack handshake.
// Options  : define IRQ_CTRL_FAST_EN to implement fast interrupts 0..14
//            (mie/mip bits 16-30, causes 16-30).
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  input  logic [14:0] irq_fast_i,
  input  logic        irq_nm_i,
  input  logic        mstatus_mie_i,
  input  logic        debug_mode_i,
  irq_ctrl_if.slave   bus,
  output logic        irq_pending_o
);

  localparam logic [11:0] c_ADDR_MIE  = 12'h304;
  localparam logic [11:0] c_ADDR_MIP  = 12'h344;

  localparam logic [1:0]  c_OP_READ   = 2'd0;
  localparam logic [1:0]  c_OP_WRITE  = 2'd1;
  localparam logic [1:0]  c_OP_SET    = 2'd2;
  localparam logic [1:0]  c_OP_CLEAR  = 2'd3;

  localparam logic [5:0]  c_CAUSE_NM  = 6'h3F;
  localparam logic [5:0]  c_CAUSE_EXT = 6'h2B;
  localparam logic [5:0]  c_CAUSE_SW  = 6'h23;
  localparam logic [5:0]  c_CAUSE_TIM = 6'h27;

  localparam logic [1:0]  c_ST_IDLE   = 2'd0;
  localparam logic [1:0]  c_ST_REQ    = 2'd1;
  localparam logic [1:0]  c_ST_ACKED  = 2'd2;

`ifdef IRQ_CTRL_FAST_EN
  localparam logic [31:0] c_IRQ_MASK  = 32'h7FFF_0888;
  localparam int          c_SYNC_W    = 19;
`else
  localparam logic [31:0] c_IRQ_MASK  = 32'h0000_0888;
  localparam int          c_SYNC_W    = 4;
`endif

  // Synchroniser bit order: [0]=software [1]=timer [2]=external [3]=nmi
  // [4+i]=fast[i] (fast bits only present when fast interrupts are built)
  logic [c_SYNC_W-1:0] w_irq_raw;
  logic [c_SYNC_W-1:0] r_sync [SYNC_STAGES];
  logic [c_SYNC_W-1:0] w_sync;

  logic [31:0] r_mie;
  logic [31:0] w_mip;
  logic [31:0] w_irqs;
  logic [31:0] w_wmask;
  logic        w_mie_wr;

  logic        r_nm_q;
  logic        w_nm_rise;
  logic        r_nmi_pend;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [5:0]  r_cause;
  logic [5:0]  w_win_cause;
  logic        w_eligible;
  logic        w_is_nm;
  logic        w_upgrade;

`ifdef IRQ_CTRL_FAST_EN
  assign w_irq_raw = {irq_fast_i, irq_nm_i, irq_external_i, irq_timer_i, irq_software_i};
`else
  // Fast inputs are unused in this configuration; fold them away.
  logic w_unused_fast;
  assign w_unused_fast = ^irq_fast_i;
  assign w_irq_raw     = {irq_nm_i, irq_external_i, irq_timer_i, irq_software_i};
`endif

  // Multi-stage flip-flop synchroniser on every interrupt line
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= w_irq_raw;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Map synchronised lines onto their mip bit positions
  always_comb begin
    w_mip     = '0;
    w_mip[3]  = w_sync[0];
    w_mip[7]  = w_sync[1];
    w_mip[11] = w_sync[2];
`ifdef IRQ_CTRL_FAST_EN
    w_mip[30:16] = w_sync[18:4];
`endif
  end

  assign w_irqs  = w_mip & r_mie;
  assign w_wmask = bus.csr_wdata_i & c_IRQ_MASK;
  assign w_mie_wr = bus.csr_access_i && (bus.csr_addr_i == c_ADDR_MIE);

  // mie register; only writable bits are ever stored
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mie <= '0;
    end else if (w_mie_wr) begin
      case (bus.csr_op_i)
        c_OP_WRITE: r_mie <= w_wmask;
        c_OP_SET:   r_mie <= r_mie | w_wmask;
        c_OP_CLEAR: r_mie <= r_mie & ~w_wmask;
        default:    r_mie <= r_mie;
      endcase
    end
  end

  // CSR read mux and address decode
  always_comb begin
    bus.csr_rdata_o = '0;
    bus.csr_hit_o   = 1'b0;
    if (bus.csr_addr_i == c_ADDR_MIE) begin
      bus.csr_rdata_o = r_mie;
      bus.csr_hit_o   = 1'b1;
    end else if (bus.csr_addr_i == c_ADDR_MIP) begin
      bus.csr_rdata_o = w_mip;
      bus.csr_hit_o   = 1'b1;
    end
  end

  assign w_nm_rise = w_sync[3] & ~r_nm_q;
  assign w_is_nm   = (r_cause == c_CAUSE_NM);

  // NMI edge detector and sticky pending flag; a new edge wins over a clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_nm_q     <= 1'b0;
      r_nmi_pend <= 1'b0;
    end else begin
      r_nm_q <= w_sync[3];
      if (w_nm_rise) begin
        r_nmi_pend <= 1'b1;
      end else if ((r_state == c_ST_REQ) && bus.irq_ack_i && w_is_nm) begin
        r_nmi_pend <= 1'b0;
      end
    end
  end

  // Fixed-priority arbiter: NMI > external > software > timer > fast[0..14]
  always_comb begin
    w_win_cause = '0;
`ifdef IRQ_CTRL_FAST_EN
    for (int i = 14; i >= 0; i--) begin
      if (w_irqs[16+i]) w_win_cause = {1'b1, 5'(16 + i)};
    end
`endif
    if (w_irqs[7])  w_win_cause = c_CAUSE_TIM;
    if (w_irqs[3])  w_win_cause = c_CAUSE_SW;
    if (w_irqs[11]) w_win_cause = c_CAUSE_EXT;
    if (r_nmi_pend) w_win_cause = c_CAUSE_NM;
  end

  assign w_eligible = !debug_mode_i && (r_nmi_pend || (mstatus_mie_i && (|w_irqs)));

  // A pending NMI takes over an outstanding maskable request unless debug masks it
  assign w_upgrade = (r_state == c_ST_REQ) && !bus.irq_ack_i && !debug_mode_i &&
                     r_nmi_pend && !w_is_nm;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= c_ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_eligible) w_state_nxt = c_ST_REQ;
      end
      c_ST_REQ: begin
        if (bus.irq_ack_i) begin
          w_state_nxt = c_ST_ACKED;
        end else if (!w_is_nm && (debug_mode_i || (!mstatus_mie_i && !r_nmi_pend))) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      c_ST_ACKED: w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.irq_req_o   = (r_state == c_ST_REQ);
    bus.irq_cause_o = r_cause;
  end

  // Cause register: captured on entry to REQ, frozen except for the NMI upgrade
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cause <= '0;
    end else if ((r_state == c_ST_IDLE) && w_eligible) begin
      r_cause <= w_win_cause;
    end else if (w_upgrade) begin
      r_cause <= c_CAUSE_NM;
    end
  end

  assign irq_pending_o = (|w_irqs) || r_nmi_pend;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Directed self-checking bench for irq_ctrl (SYNC_STAGES = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  localparam logic [11:0] c_MIE = 12'h304;
  localparam logic [11:0] c_MIP = 12'h344;
  localparam logic [1:0]  c_WR  = 2'd1;
  localparam logic [1:0]  c_SET = 2'd2;
  localparam logic [1:0]  c_CLR = 2'd3;

`ifdef IRQ_CTRL_FAST_EN
  localparam logic [31:0] c_EXP_SET = 32'h0001_0008;
  localparam logic [31:0] c_EXP_CLR = 32'h0001_0000;
  localparam logic [31:0] c_EXP_ALL = 32'h7FFF_0888;
`else
  localparam logic [31:0] c_EXP_SET = 32'h0000_0008;
  localparam logic [31:0] c_EXP_CLR = 32'h0000_0000;
  localparam logic [31:0] c_EXP_ALL = 32'h0000_0888;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        irq_software_i = 1'b0;
  logic        irq_timer_i = 1'b0;
  logic        irq_external_i = 1'b0;
  logic [14:0] irq_fast_i = '0;
  logic        irq_nm_i = 1'b0;
  logic        mstatus_mie_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic        irq_pending_o;

  int n_assert = 0;
  int n_fail   = 0;

  irq_ctrl_if bus_if ();

  irq_ctrl #(.SYNC_STAGES(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .irq_software_i (irq_software_i),
    .irq_timer_i    (irq_timer_i),
    .irq_external_i (irq_external_i),
    .irq_fast_i     (irq_fast_i),
    .irq_nm_i       (irq_nm_i),
    .mstatus_mie_i  (mstatus_mie_i),
    .debug_mode_i   (debug_mode_i),
    .bus            (bus_if),
    .irq_pending_o  (irq_pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic csr_op(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
    bus_if.csr_access_i = 1'b1;
    bus_if.csr_addr_i   = addr;
    bus_if.csr_op_i     = op;
    bus_if.csr_wdata_i  = wd;
    tick(1);
    bus_if.csr_access_i = 1'b0;
    bus_if.csr_op_i     = 2'd0;
    bus_if.csr_wdata_i  = '0;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    bus_if.csr_addr_i = addr;
    #1;
    check(tag, bus_if.csr_rdata_o, exp);
  endtask

  task automatic check_req(input string tag, input logic req, input logic [5:0] cause);
    check({tag, "_req"}, {31'd0, bus_if.irq_req_o}, {31'd0, req});
    if (req) check({tag, "_cause"}, {26'd0, bus_if.irq_cause_o}, {26'd0, cause});
  endtask

  task automatic ack_once();
    bus_if.irq_ack_i = 1'b1;
    tick(1);
    bus_if.irq_ack_i = 1'b0;
  endtask

  initial begin
    bus_if.csr_access_i = 1'b0;
    bus_if.csr_addr_i   = c_MIE;
    bus_if.csr_op_i     = 2'd0;
    bus_if.csr_wdata_i  = '0;
    bus_if.irq_ack_i    = 1'b0;

    // Reset state
    tick(2);
    check_req("rst", 1'b0, 6'h00);
    check("rst_cause", {26'd0, bus_if.irq_cause_o}, 32'd0);
    check("rst_pending", {31'd0, irq_pending_o}, 32'd0);
    csr_rd("rst_mie", c_MIE, 32'd0);
    rst_ni = 1'b1;

    // mie SET / CLEAR / WRITE with masking
    csr_op(c_MIE, c_SET, 32'h0001_0008);
    csr_rd("mie_set", c_MIE, c_EXP_SET);
    csr_op(c_MIE, c_CLR, 32'h0000_0008);
    csr_rd("mie_clr", c_MIE, c_EXP_CLR);
    csr_op(c_MIE, c_WR, 32'hFFFF_FFFF);
    csr_rd("mie_wr", c_MIE, c_EXP_ALL);
    csr_op(c_MIP, c_WR, 32'h0000_0000);
    csr_rd("mip_wr_ignored", c_MIE, c_EXP_ALL);
    bus_if.csr_addr_i = c_MIP;
    #1;
    check("hit_mip", {31'd0, bus_if.csr_hit_o}, 32'd1);
    csr_rd("rd_other", 12'h300, 32'd0);
    check("hit_other", {31'd0, bus_if.csr_hit_o}, 32'd0);
    check_req("no_src", 1'b0, 6'h00);

    // Timer request latency
    csr_op(c_MIE, c_WR, 32'h0000_0880);
    mstatus_mie_i = 1'b1;
    irq_timer_i   = 1'b1;
    tick(1);
    csr_rd("mip_e0", c_MIP, 32'd0);
    tick(1);
    csr_rd("mip_e1", c_MIP, 32'h80);
    check_req("tim_e1", 1'b0, 6'h00);
    tick(1);
    check_req("tim_e2", 1'b1, 6'h27);
    check("tim_pending", {31'd0, irq_pending_o}, 32'd1);

    // Ack, ACKED gap, re-request two cycles later
    ack_once();
    check_req("acked", 1'b0, 6'h00);
    tick(1);
    check_req("idle", 1'b0, 6'h00);
    tick(1);
    check_req("rearm", 1'b1, 6'h27);

    // NMI upgrades an outstanding timer request
    irq_nm_i = 1'b1;
    tick(1);
    irq_nm_i = 1'b0;
    tick(2);
    check_req("nm_pre", 1'b1, 6'h27);
    tick(1);
    check_req("nm_up", 1'b1, 6'h3F);
    ack_once();
    check_req("nm_acked", 1'b0, 6'h00);
    tick(1);
    check_req("nm_idle", 1'b0, 6'h00);
    tick(1);
    check_req("nm_cleared", 1'b1, 6'h27);

    // Retire the timer request and let the line fall away
    irq_timer_i = 1'b0;
    ack_once();
    tick(2);
    check_req("quiet", 1'b0, 6'h00);
    check("quiet_pending", {31'd0, irq_pending_o}, 32'd0);

    // Priority: external over software (and fast[2] when built)
    csr_op(c_MIE, c_WR, 32'hFFFF_FFFF);
    irq_external_i = 1'b1;
    irq_software_i = 1'b1;
    irq_fast_i     = 15'h0004;
    tick(3);
    check_req("prio_ext", 1'b1, 6'h2B);
    irq_external_i = 1'b0;
    tick(3);
    check_req("ext_hold", 1'b1, 6'h2B);
    ack_once();
    tick(2);
    check_req("prio_sw", 1'b1, 6'h23);

    // Global enable withdraws, pending still reported for WFI
    mstatus_mie_i = 1'b0;
    tick(1);
    check_req("wd_mie", 1'b0, 6'h00);
    tick(1);
    check_req("wd_mie_hold", 1'b0, 6'h00);
    check("wd_pending", {31'd0, irq_pending_o}, 32'd1);
    mstatus_mie_i = 1'b1;
    tick(1);
    check_req("re_mie", 1'b1, 6'h23);
    debug_mode_i = 1'b1;
    tick(1);
    check_req("wd_dbg", 1'b0, 6'h00);
    debug_mode_i = 1'b0;
    tick(1);
    check_req("re_dbg", 1'b1, 6'h23);

    // Asynchronous reset while in REQ
    rst_ni = 1'b0;
    #1;
    check_req("arst", 1'b0, 6'h00);
    check("arst_cause", {26'd0, bus_if.irq_cause_o}, 32'd0);
    check("arst_pending", {31'd0, irq_pending_o}, 32'd0);
    csr_rd("arst_mie", c_MIE, 32'd0);
    tick(1);
    rst_ni = 1'b1;
    tick(1);
    csr_rd("resync_e0", c_MIP, 32'd0);
    tick(1);
    csr_rd("resync_e1", c_MIP, 32'h8);
    check_req("resync_noreq", 1'b0, 6'h00);
    csr_op(c_MIE, c_WR, 32'h0000_0008);
    tick(1);
    check_req("resync_req", 1'b1, 6'h23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Machine-mode interrupt controller for the RV32 core. It synchronises the software, timer, external, fast and non-maskable interrupt lines, and owns the `mie` CSR (0x304) and the read-only `mip` CSR (0x344). It arbitrates enabled pending sources by fixed priority and presents one request with an `exc_cause_e`-encoded cause to the core controller over a req/ack handshake. It sits between the SoC interrupt sources and the core's ID/controller stage, next to the CSR file.

## Interface
- `SYNC_STAGES`, default 2: flip-flop synchroniser depth on every interrupt input. Legal values are 1 to 3.
- `clk_i` in, 1: core clock.
- `rst_ni` in, 1: asynchronous active-low reset.
- `irq_software_i` in, 1: level, machine software interrupt.
- `irq_timer_i` in, 1: level, machine timer interrupt.
- `irq_external_i` in, 1: level, machine external interrupt.
- `irq_fast_i` in, 15: level, fast interrupts 0 to 14.
- `irq_nm_i` in, 1: non-maskable interrupt, rising-edge triggered.
- `mstatus_mie_i` in, 1: global interrupt enable, from `mstatus` bit 3.
- `debug_mode_i` in, 1: core is in debug mode. Masks all sources, including NMI.
- `csr_access_i` in, 1: CSR instruction valid this cycle.
- `csr_addr_i` in, 12: CSR address.
- `csr_op_i` in, 2: `csr_op_e` (READ, WRITE, SET, CLEAR).
- `csr_wdata_i` in, 32: CSR write operand.
- `csr_rdata_o` out, 32: read data. Combinational.
- `csr_hit_o` out, 1: the address is 0x304 or 0x344.
- `irq_req_o` out, 1: interrupt request to the core.
- `irq_cause_o` out, 6: `exc_cause_e` value. Valid while `irq_req_o` is high.
- `irq_ack_i` in, 1: the core takes the request.
- `irq_pending_o` out, 1: WFI wake. Equals `|(mip & mie)` or NMI pending, regardless of `mstatus_mie_i`.

## Operation
- Enable mask for `mie` and `mip`: bits 3, 7, 11 and 16–30. All other bits read 0.
- `mip` bit mapping: bit 3 = software, bit 7 = timer, bit 11 = external, bit 16+i = fast[i]. Values come from the synchroniser outputs.
- `mie` is reset to 0. Writes only happen when `csr_access_i` is high and `csr_addr_i` is 0x304:
  - WRITE: `mie = wdata & mask`.
  - SET: `mie |= wdata & mask`.
  - CLEAR: `mie &= ~(wdata & mask)`.
  - READ: no change.
- Writes to 0x344 are ignored. `csr_hit_o` is still 1.
- Any other address: `csr_rdata_o` = 0 and `csr_hit_o` = 0.
- NMI handling:
  - A rising edge on the synchronised `irq_nm_i` sets `nmi_pend`.
  - `nmi_pend` is cleared only by an acknowledge whose cause is NM.
  - Further edges while `nmi_pend` is set are merged into it.
- Priority, highest first:
  1. NMI, cause {1,31}.
  2. External, cause {1,11}.
  3. Software, cause {1,3}.
  4. Timer, cause {1,7}.
  5. fast[0] to fast[14], cause {1,16+i}; a lower index has higher priority.
- `eligible` is true when `!debug_mode_i`, and either `nmi_pend` is set or (`mstatus_mie_i` is high and `mip & mie` is nonzero).
- FSM state IDLE:
  - If `eligible`, register the winning cause and go to REQ.
  - `irq_req_o` = 0.
- FSM state REQ:
  - `irq_req_o` = 1. The cause is frozen.
  - `irq_ack_i` → ACKED. If the cause is NM, clear `nmi_pend` on that same edge.
  - If `nmi_pend` is set and the cause is not NM, the cause upgrades to NM on the next edge and the state stays REQ.
  - If `mstatus_mie_i` = 0 or `debug_mode_i` = 1, and the cause is not NM, withdraw to IDLE.
  - A maskable source that deasserts does not withdraw the request.
- FSM state ACKED:
  - Lasts one cycle, with `irq_req_o` = 0, so the core's `mstatus` update can land.
  - Then goes to IDLE.
- Simultaneous events:
  - Ack and NMI edge in the same cycle: the ack retires the old cause and `nmi_pend` stays set.
  - Ack and a CSR write in the same cycle: both take effect.
- Reset values, including reset mid-operation: FSM = IDLE, `irq_req_o` = 0, `irq_cause_o` = 0, `mie` = 0, synchronisers = 0, `nmi_pend` = 0, `irq_pending_o` = 0.

## Timing
- A source asserted before edge 0 appears in `mip` after `SYNC_STAGES` edges. `irq_req_o` rises one edge later, a latency of `SYNC_STAGES`+1 cycles (3 with the default).
- NMI: the edge is detected at synchroniser output, and `irq_req_o` rises at `SYNC_STAGES`+2.
- A `mie` write becomes visible to arbitration and to reads on the next edge.
- `csr_rdata_o` reflects registered state in the same cycle.
- Minimum spacing between two accepted requests: request, ack, ACKED, then IDLE. A new request can assert 2 cycles after the ack.
- `irq_cause_o` is stable from `irq_req_o` rising until ack or withdraw. The only exception is the NM upgrade.

## Configuration
- `IRQ_CTRL_FAST_EN` defined: fast interrupts are implemented as described.
- `IRQ_CTRL_FAST_EN` undefined:
  - `irq_fast_i` is ignored and its synchronisers are removed.
  - `mie` and `mip` bits 16–30 are hard-wired to 0, so reads return 0 and writes have no effect.
  - Causes 16–30 are never produced.

## Test plan
- Reset, then write `mie` with 0x0000_0880, `mstatus_mie_i` = 1, raise `irq_timer_i`. Expect `mip` = 0x80 after 2 cycles and `irq_req_o` = 1 with cause 0x27 at cycle 3. Ack: `irq_req_o` drops for at least 1 cycle.
- Raise external, software and fast[2] together with all enabled. Expect cause 0x2B. Ack, drop external, and the next request has cause 0x23.
- CSR SET 0x0001_0008, then CLEAR 0x0000_0008, then WRITE 0xFFFF_FFFF. Expect reads of 0x0001_0008, 0x0001_0000, and 0x7FFF_0888 (without `IRQ_CTRL_FAST_EN`: 0x888).
- Request with cause 0x27 outstanding, then pulse `irq_nm_i`. Expect the cause to change to 0x3F before ack. Ack clears `nmi_pend`, and a timer request follows 2 cycles later.
- With `mstatus_mie_i` = 0, raise timer with `mie` bit 7 set. Expect `irq_pending_o` = 1 and `irq_req_o` = 0. Set `debug_mode_i` during REQ and expect withdraw.
- Assert `rst_ni` low in REQ. Expect all outputs 0 immediately, and no request until a source is re-sampled after reset.
